decode_scoreboard: RTL and testbench

- Parametrised register-hazard scoreboard for the decode stage. It generalises the single-reserve, single-bit regfile valid tracking to NRD source ports, NWB write-back release ports, and multi-writer in-flight counters per register.
- It decides each cycle whether the instruction presented by decode may issue to execute. It records destination reservations and releases them when mem/wb stages write back.
- Sits between decode and the regfile read path and drives decode's stall output.

---
 rtl/decode_scoreboard.sv | 107 ++++++++++
 tb/tb_decode_scoreboard.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/decode_scoreboard.sv
// Decode-stage register-hazard scoreboard: per-register in-flight writer counters,
// multi-port source hazard checks and multi-port write-back release.
module decode_scoreboard #(
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWB  = 2,
  parameter int CW   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [NRD*5-1:0]  issue_rs,
  input  logic [NRD-1:0]    issue_rs_used,
  input  logic [4:0]        issue_rd,
  input  logic              issue_rd_en,
  input  logic              ex_stall,
  input  logic [NWB*5-1:0]  wb_rd,
  input  logic [NWB-1:0]    wb_en,
  input  logic              flush,
  output logic              issue_fire,
  output logic              stall,
  output logic [NREG-1:0]   busy,
  output logic              err
);

  localparam int RELW = $clog2(NWB + 1);
  localparam int SW   = ((CW > RELW) ? CW : RELW) + 1;
  localparam logic [CW-1:0] CMAX = '1;

  logic [CW-1:0] r_cnt [NREG];
  logic          r_err;

  logic [SW-1:0] w_rel  [NREG];
  logic [SW-1:0] w_sum  [NREG];
  logic [CW-1:0] w_eff  [NREG];
  logic [CW-1:0] w_next [NREG];
  logic [NREG-1:0] w_under;
  logic          w_raw_haz;
  logic          w_waw_full;
  logic [4:0]    w_rs;

  // Releases this cycle and the occupancy seen by decode once they complete.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      w_rel[i] = '0;
      for (int k = 0; k < NWB; k++) begin
        if (i != 0 && wb_en[k] && wb_rd[5*k +: 5] == 5'(i))
          w_rel[i] = w_rel[i] + SW'(1);
      end
      if ({{(SW-CW){1'b0}}, r_cnt[i]} > w_rel[i])
        w_eff[i] = CW'({{(SW-CW){1'b0}}, r_cnt[i]} - w_rel[i]);
      else
        w_eff[i] = '0;
    end
  end

  always_comb begin
    w_raw_haz = 1'b0;
    w_rs      = '0;
    for (int k = 0; k < NRD; k++) begin
      w_rs = issue_rs[5*k +: 5];
      if (issue_rs_used[k] && w_rs != 5'd0 && int'(w_rs) < NREG && w_eff[w_rs] != '0)
        w_raw_haz = 1'b1;
    end
    w_waw_full = issue_rd_en && issue_rd != 5'd0 && int'(issue_rd) < NREG &&
                 w_eff[issue_rd] == CMAX;
  end

  assign stall      = issue_valid & (ex_stall | w_raw_haz | w_waw_full);
  assign issue_fire = issue_valid & ~stall;

  // Net each counter by this cycle's issue and releases; over-release clamps to zero.
  always_comb begin
    w_under = '0;
    for (int i = 0; i < NREG; i++) begin
      w_sum[i] = {{(SW-CW){1'b0}}, r_cnt[i]};
      if (i != 0 && issue_fire && issue_rd_en && issue_rd == 5'(i))
        w_sum[i] = w_sum[i] + SW'(1);
      if (w_rel[i] > w_sum[i]) begin
        w_under[i] = 1'b1;
        w_next[i]  = '0;
      end else begin
        w_next[i]  = CW'(w_sum[i] - w_rel[i]);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
      r_err <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
    end else begin
      r_cnt[0] <= '0;
      for (int i = 1; i < NREG; i++) r_cnt[i] <= w_next[i];
      r_err <= r_err | (|w_under);
    end
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) busy[i] = (i != 0) && (r_cnt[i] != '0);
  end

  assign err = r_err;

endmodule

// File: tb/tb_decode_scoreboard.sv
// Directed table of issue/release vectors for decode_scoreboard with hand-computed
// expectations, plus a hand-written asynchronous reset sequence.
module tb_decode_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [9:0]  issue_rs;
  logic [1:0]  issue_rs_used;
  logic [4:0]  issue_rd;
  logic        issue_rd_en;
  logic        ex_stall;
  logic [9:0]  wb_rd;
  logic [1:0]  wb_en;
  logic        flush;
  logic        issue_fire;
  logic        stall;
  logic [31:0] busy;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  decode_scoreboard #(.NREG(32), .NRD(2), .NWB(2), .CW(2)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_rs(issue_rs),
    .issue_rs_used(issue_rs_used), .issue_rd(issue_rd), .issue_rd_en(issue_rd_en),
    .ex_stall(ex_stall), .wb_rd(wb_rd), .wb_en(wb_en), .flush(flush),
    .issue_fire(issue_fire), .stall(stall), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [4:0]  rs0, rs1;
    logic [1:0]  used;
    logic [4:0]  rd;
    logic        rd_en;
    logic        exs;
    logic [4:0]  wb0, wb1;
    logic [1:0]  wben;
    logic        fl;
    logic        e_fire;
    logic        e_stall;
    logic [31:0] e_busy;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [4:0] r0, logic [4:0] r1, logic [1:0] u,
                              logic [4:0] d, logic de, logic x, logic [4:0] w0,
                              logic [4:0] w1, logic [1:0] we, logic f, logic ef,
                              logic es, logic [31:0] eb, logic ee);
    vec_t t;
    t.valid = v; t.rs0 = r0; t.rs1 = r1; t.used = u; t.rd = d; t.rd_en = de;
    t.exs = x; t.wb0 = w0; t.wb1 = w1; t.wben = we; t.fl = f;
    t.e_fire = ef; t.e_stall = es; t.e_busy = eb; t.e_err = ee;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t t);
    issue_valid   = t.valid;
    issue_rs      = {t.rs1, t.rs0};
    issue_rs_used = t.used;
    issue_rd      = t.rd;
    issue_rd_en   = t.rd_en;
    ex_stall      = t.exs;
    wb_rd         = {t.wb1, t.wb0};
    wb_en         = t.wben;
    flush         = t.fl;
  endtask

  initial begin
    reset = 1'b1;
    drive(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0));
    // valid, rs0, rs1, used, rd, rd_en, ex_stall, wb0, wb1, wb_en, flush | fire, stall, busy, err
    tbl.push_back(mk(1, 3,4,2'b11, 0,0, 0, 0,0,2'b00, 0,  1,0,32'h0,   0)); // 0 no hazards
    tbl.push_back(mk(1, 0,0,2'b00, 5,1, 0, 0,0,2'b00, 0,  1,0,32'h20,  0)); // 1 reserve r5
    tbl.push_back(mk(1, 5,0,2'b01, 0,0, 0, 0,0,2'b00, 0,  0,1,32'h20,  0)); // 2 RAW on r5
    tbl.push_back(mk(1, 5,0,2'b01, 0,0, 0, 0,5,2'b10, 0,  1,0,32'h0,   0)); // 3 same-cycle wb
    tbl.push_back(mk(1, 0,0,2'b00, 7,1, 0, 0,0,2'b00, 0,  1,0,32'h80,  0)); // 4 r7 cnt1
    tbl.push_back(mk(1, 0,0,2'b00, 7,1, 0, 0,0,2'b00, 0,  1,0,32'h80,  0)); // 5 r7 cnt2
    tbl.push_back(mk(1, 0,0,2'b00, 7,1, 0, 0,0,2'b00, 0,  1,0,32'h80,  0)); // 6 r7 cnt3
    tbl.push_back(mk(1, 0,0,2'b00, 7,1, 0, 0,0,2'b00, 0,  0,1,32'h80,  0)); // 7 WAW full
    tbl.push_back(mk(1, 0,0,2'b00, 7,1, 0, 7,0,2'b01, 0,  1,0,32'h80,  0)); // 8 net out, cnt3
    tbl.push_back(mk(1, 0,0,2'b00, 7,1, 0, 0,0,2'b00, 0,  0,1,32'h80,  0)); // 9 still full
    tbl.push_back(mk(0, 0,0,2'b00, 0,0, 0, 7,7,2'b11, 0,  0,0,32'h80,  0)); // 10 double release
    tbl.push_back(mk(0, 0,0,2'b00, 0,0, 0, 7,0,2'b01, 0,  0,0,32'h0,   0)); // 11 r7 empty
    tbl.push_back(mk(1, 0,0,2'b00, 9,1, 0, 0,0,2'b00, 0,  1,0,32'h200, 0)); // 12 r9 cnt1
    tbl.push_back(mk(0, 0,0,2'b00, 0,0, 0, 9,9,2'b11, 0,  0,0,32'h0,   1)); // 13 underflow
    tbl.push_back(mk(0, 0,0,2'b00, 0,0, 0, 0,0,2'b00, 0,  0,0,32'h0,   1)); // 14 err sticky
    tbl.push_back(mk(1, 0,0,2'b00, 2,1, 0, 0,0,2'b00, 0,  1,0,32'h4,   1)); // 15 r2 cnt1
    tbl.push_back(mk(1, 0,0,2'b00, 2,1, 0, 0,0,2'b00, 0,  1,0,32'h4,   1)); // 16 r2 cnt2
    tbl.push_back(mk(1, 0,0,2'b00, 6,1, 0, 0,0,2'b00, 0,  1,0,32'h44,  1)); // 17 r6 cnt1
    tbl.push_back(mk(1, 0,0,2'b00, 4,1, 0, 0,0,2'b00, 1,  1,0,32'h0,   1)); // 18 flush drops inc
    tbl.push_back(mk(1, 4,2,2'b11, 0,0, 0, 0,0,2'b00, 0,  1,0,32'h0,   1)); // 19 r4,r2 clear
    tbl.push_back(mk(1, 0,0,2'b00, 3,1, 0, 0,0,2'b00, 0,  1,0,32'h8,   1)); // 20 r3 cnt1
    tbl.push_back(mk(1, 1,0,2'b01, 8,1, 1, 0,0,2'b00, 0,  0,1,32'h8,   1)); // 21 ex_stall
    tbl.push_back(mk(1, 0,0,2'b01, 0,1, 0, 0,0,2'b01, 0,  1,0,32'h8,   1)); // 22 x0 ignored
    tbl.push_back(mk(1, 0,3,2'b10, 0,0, 0, 0,0,2'b00, 0,  0,1,32'h8,   1)); // 23 RAW port1

    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("reset busy", busy, 32'h0);
    chk("reset err", {31'b0, err}, 32'h0);
    chk("reset stall", {31'b0, stall}, 32'h0);

    for (int n = 0; n < tbl.size(); n++) begin
      drive(tbl[n]);
      #4;
      chk($sformatf("v%0d fire", n), {31'b0, issue_fire}, {31'b0, tbl[n].e_fire});
      chk($sformatf("v%0d stall", n), {31'b0, stall}, {31'b0, tbl[n].e_stall});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d busy", n), busy, tbl[n].e_busy);
      chk($sformatf("v%0d err", n), {31'b0, err}, {31'b0, tbl[n].e_err});
    end

    // Asynchronous reset while the port-1 RAW hazard on r3 is still presented.
    #2 reset = 1'b1;
    #1;
    chk("async busy", busy, 32'h0);
    chk("async err", {31'b0, err}, 32'h0);
    chk("async stall", {31'b0, stall}, 32'h0);
    chk("async fire", {31'b0, issue_fire}, 32'h1);
    @(posedge clk);
    #2 reset = 1'b0;
    drive(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0));
    @(posedge clk);
    #1;
    chk("post-reset busy", busy, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
